// File: rtl/force_result_collector.sv
// force_result_collector: captures LJ force triplets with (ref,nb) tags, then drains them in order over a ready/valid port
module force_result_collector #(
    parameter int DATA_WIDTH            = 32,
    parameter int REF_PARTICLE_NUM      = 100,
    parameter int NEIGHBOR_PARTICLE_NUM = 100,
    parameter int DEPTH                 = 10000,
    parameter int ADDR_WIDTH            = 14,
    parameter int REF_ID_WIDTH          = 7,
    parameter int NB_ID_WIDTH           = 7
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     in_force_x,
    input  logic [DATA_WIDTH-1:0]     in_force_y,
    input  logic [DATA_WIDTH-1:0]     in_force_z,
    input  logic                      in_valid,
    input  logic                      in_done,
    output logic [3*DATA_WIDTH-1:0]   out_data,
    output logic [REF_ID_WIDTH-1:0]   out_ref_id,
    output logic [NB_ID_WIDTH-1:0]    out_nb_id,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ADDR_WIDTH:0]       result_count,
    output logic                      overflow,
    output logic                      protocol_error,
    output logic                      readout_done
);
    localparam int W = 3*DATA_WIDTH + REF_ID_WIDTH + NB_ID_WIDTH;
    typedef enum logic [1:0] {COLLECT, DRAIN, FINISH} state_t;
    state_t state, state_nxt;
    logic [W-1:0]            mem [DEPTH];
    logic [ADDR_WIDTH-1:0]   wr_addr, rd_addr, rd_nxt, rd_sel;
    logic [REF_ID_WIDTH-1:0] ref_idx;
    logic [NB_ID_WIDTH-1:0]  nb_idx;
    logic                    fetched, capture, accept, last, load;
    assign capture      = state == COLLECT && in_valid && result_count < (ADDR_WIDTH+1)'(DEPTH);
    assign accept       = out_valid && out_ready;
    assign rd_nxt       = rd_addr + ADDR_WIDTH'(1);
    assign last         = ({1'b0, rd_addr} + (ADDR_WIDTH+1)'(1)) == result_count;
    assign rd_sel       = accept ? rd_nxt : rd_addr;
    assign load         = state == DRAIN && ((!out_valid && !fetched) || (accept && !last));
    assign readout_done = state == FINISH;
    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= COLLECT;
        else     state <= state_nxt;
    end
    // next state: leave COLLECT on in_done (straight to FINISH if nothing was captured), leave DRAIN on last accept
    always_comb begin
        state_nxt = state;
        if (state == COLLECT && in_done)
            state_nxt = (result_count == '0 && !capture) ? FINISH : DRAIN;
        if (state == DRAIN && accept && last)
            state_nxt = FINISH;
    end
    // result storage, never cleared by reset
    always_ff @(posedge clk) begin
        if (capture) mem[wr_addr] <= {ref_idx, nb_idx, in_force_z, in_force_y, in_force_x};
    end
    // capture counters, sticky flags and the drain pipeline (fetched = next entry loaded but not yet shown)
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr        <= '0;
            rd_addr        <= '0;
            result_count   <= '0;
            ref_idx        <= '0;
            nb_idx         <= '0;
            fetched        <= 1'b0;
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_ref_id     <= '0;
            out_nb_id      <= '0;
            overflow       <= 1'b0;
            protocol_error <= 1'b0;
        end else begin
            if (capture) begin
                wr_addr      <= wr_addr + ADDR_WIDTH'(1);
                result_count <= result_count + (ADDR_WIDTH+1)'(1);
                nb_idx       <= nb_idx == NB_ID_WIDTH'(NEIGHBOR_PARTICLE_NUM-1) ? '0 : nb_idx + NB_ID_WIDTH'(1);
                if (nb_idx == NB_ID_WIDTH'(NEIGHBOR_PARTICLE_NUM-1))
                    ref_idx <= ref_idx == REF_ID_WIDTH'(REF_PARTICLE_NUM-1) ? '0 : ref_idx + REF_ID_WIDTH'(1);
            end
            if (state == COLLECT && in_valid && !capture) overflow <= 1'b1;
            if (state != COLLECT && in_valid) protocol_error <= 1'b1;
            if (state == DRAIN) begin
                if (accept) begin
                    out_valid <= 1'b0;
                    rd_addr   <= rd_nxt;
                    fetched   <= !last;
                end else if (fetched) begin
                    out_valid <= 1'b1;
                    fetched   <= 1'b0;
                end else if (!out_valid) begin
                    fetched   <= 1'b1;
                end
            end
            if (load) {out_ref_id, out_nb_id, out_data} <= mem[rd_sel];
        end
    end
endmodule

// File: tb/tb_force_result_collector.sv
// tb_force_result_collector: directed checks of capture, tagging, overflow, drain timing, backpressure and reset
module tb_force_result_collector;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_done, out_ready;
    logic [31:0] in_force_x, in_force_y, in_force_z;
    logic [95:0] b_data, s_data;
    logic [6:0]  b_ref, b_nb, s_ref, s_nb;
    logic        b_valid, b_ovf, b_perr, b_done, s_valid, s_ovf, s_perr, s_done;
    logic [14:0] b_count;
    logic [3:0]  s_count;
    int          errors = 0, checks = 0;
    logic [95:0] q_data[$];
    logic [6:0]  q_ref[$], q_nb[$];
    int          q_cyc[$];
    int          s_beats;
    logic [95:0] s_last;

    always #5 clk = ~clk;

    force_result_collector #(.DEPTH(256)) dut (
        .clk(clk), .rst(rst), .in_force_x(in_force_x), .in_force_y(in_force_y), .in_force_z(in_force_z),
        .in_valid(in_valid), .in_done(in_done), .out_data(b_data), .out_ref_id(b_ref), .out_nb_id(b_nb),
        .out_valid(b_valid), .out_ready(out_ready), .result_count(b_count), .overflow(b_ovf),
        .protocol_error(b_perr), .readout_done(b_done)
    );

    force_result_collector #(.DEPTH(4), .ADDR_WIDTH(3)) dut_small (
        .clk(clk), .rst(rst), .in_force_x(in_force_x), .in_force_y(in_force_y), .in_force_z(in_force_z),
        .in_valid(in_valid), .in_done(in_done), .out_data(s_data), .out_ref_id(s_ref), .out_nb_id(s_nb),
        .out_valid(s_valid), .out_ready(out_ready), .result_count(s_count), .overflow(s_ovf),
        .protocol_error(s_perr), .readout_done(s_done)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [95:0] trip(input int i);
        return {32'h40400000 + 32'(i), 32'h40000000 + 32'(i), 32'h3F800000 + 32'(i)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; in_done = 1'b0; out_ready = 1'b0;
        in_force_x = '0; in_force_y = '0; in_force_z = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic push(input int n, input bit done_last);
        logic [95:0] t;
        for (int i = 0; i < n; i++) begin
            t = trip(i);
            {in_force_z, in_force_y, in_force_x} = t;
            in_valid = 1'b1;
            in_done  = done_last && i == n-1;
            tick();
        end
        in_valid = 1'b0;
        in_done  = 1'b0;
    endtask

    task automatic drain(input int budget);
        q_data.delete(); q_ref.delete(); q_nb.delete(); q_cyc.delete();
        s_beats = 0;
        s_last  = '0;
        out_ready = 1'b1;
        for (int c = 0; c < budget && !b_done; c++) begin
            if (b_valid) begin
                q_data.push_back(b_data); q_ref.push_back(b_ref); q_nb.push_back(b_nb); q_cyc.push_back(c);
            end
            if (s_valid) begin
                s_beats++;
                s_last = s_data;
            end
            tick();
        end
        check("drain_done", b_done, 1'b1);
        out_ready = 1'b0;
    endtask

    initial begin
        bit seen;
        // basic capture and drain
        do_reset();
        check("reset_state", {b_count, b_valid, b_ovf, b_perr, b_done}, '0);
        push(3, 1'b0);
        check("count3", b_count, 15'd3);
        in_done = 1'b1;
        tick();
        in_done = 1'b0;
        drain(40);
        check("beats3", q_data.size(), 3);
        if (q_data.size() == 3) begin
            check("first_valid_cyc", q_cyc[0], 2);
            check("spacing01", q_cyc[1] - q_cyc[0], 2);
            check("spacing12", q_cyc[2] - q_cyc[1], 2);
            check("data0", q_data[0], 96'h40400000_40000000_3F800000);
            check("data1", q_data[1], 96'h40400001_40000001_3F800001);
            check("data2", q_data[2], trip(2));
            check("tags0", {q_ref[0], q_nb[0]}, {7'd0, 7'd0});
            check("tags1", {q_ref[1], q_nb[1]}, {7'd0, 7'd1});
            check("tags2", {q_ref[2], q_nb[2]}, {7'd0, 7'd2});
        end
        check("valid_after_finish", b_valid, 1'b0);
        check("small_no_ovf", s_ovf, 1'b0);
        // tag wrap on the large instance, storage full on the small one
        do_reset();
        push(205, 1'b0);
        check("count205", b_count, 15'd205);
        check("small_count_cap", s_count, 4'd4);
        check("small_ovf", s_ovf, 1'b1);
        check("big_no_ovf", b_ovf, 1'b0);
        in_done = 1'b1;
        tick();
        in_done = 1'b0;
        drain(600);
        check("beats205", q_data.size(), 205);
        if (q_data.size() == 205) begin
            check("tags99", {q_ref[99], q_nb[99]}, {7'd0, 7'd99});
            check("tags100", {q_ref[100], q_nb[100]}, {7'd1, 7'd0});
            check("tags204", {q_ref[204], q_nb[204]}, {7'd2, 7'd4});
            check("data204", q_data[204], trip(204));
        end
        check("small_beats", s_beats, 4);
        check("small_last", s_last, trip(3));
        // backpressure, same-cycle done capture, protocol error, reset mid-drain
        do_reset();
        push(2, 1'b1);
        check("count_done_cycle", b_count, 15'd2);
        for (int i = 0; i < 10 && !b_valid; i++) tick();
        check("bp_valid", b_valid, 1'b1);
        check("bp_data0", b_data, trip(0));
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_hold", {b_valid, b_data, b_ref, b_nb}, {1'b1, trip(0), 7'd0, 7'd0});
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("gap_after_accept", b_valid, 1'b0);
        tick();
        check("second_beat", {b_valid, b_data, b_ref, b_nb}, {1'b1, trip(1), 7'd0, 7'd1});
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("protocol_error", b_perr, 1'b1);
        check("count_unchanged", b_count, 15'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_data", b_data, '0);
        check("rst_flags", {b_valid, b_ref, b_nb, b_count, b_ovf, b_perr, b_done}, '0);
        // done with nothing captured
        do_reset();
        in_done = 1'b1;
        tick();
        in_done = 1'b0;
        check("empty_finish", b_done, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (b_valid) seen = 1'b1;
        end
        check("empty_no_valid", seen, 1'b0);
        check("empty_done_held", b_done, 1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
